// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32-cycle shift-add multiply and restoring divide.
// Divide-by-zero and signed overflow take a single-cycle fast path to DONE.
module muldiv_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    input  logic [4:0]  rd_in,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [4:0]  rd_out
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state, state_next;
    logic [2:0]  op;
    logic        sign_a, sign_b;
    logic [31:0] opnd;
    logic [63:0] acc;
    logic [4:0]  count;

    logic        is_div, signed_a, signed_b, neg_a, neg_b, div_zero, div_ovf, fast;
    logic [31:0] mag_a, mag_b, fast_result;

    // NOTE: every signal driven here gets a value on every path, so no latches are inferred.
    always_comb begin
        is_div   = funct3[2];
        signed_a = is_div ? ~funct3[0] : (funct3[1:0] != 2'b11);
        signed_b = is_div ? ~funct3[0] : ~funct3[1];
        neg_a    = signed_a & operand_a[31];
        neg_b    = signed_b & operand_b[31];
        mag_a    = neg_a ? -operand_a : operand_a;
        mag_b    = neg_b ? -operand_b : operand_b;
        div_zero = is_div & (operand_b == 32'd0);
        div_ovf  = is_div & ~funct3[0] & (operand_a == 32'h8000_0000) & (operand_b == 32'hFFFF_FFFF);
        fast     = div_zero | div_ovf;
        if (div_zero) fast_result = funct3[1] ? operand_a : 32'hFFFF_FFFF;
        else          fast_result = funct3[1] ? 32'd0 : 32'h8000_0000;
    end

    // acc holds {partial product, multiplier} or {partial remainder, dividend/quotient}.
    logic [32:0] mul_sum, div_shift, div_diff;
    logic [63:0] acc_step;

    always_comb begin
        mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
        div_shift = {acc[63:32], acc[31]};
        div_diff  = div_shift - {1'b0, opnd};
        if (op[2])
            acc_step = div_diff[32] ? {div_shift[31:0], acc[30:0], 1'b0}
                                    : {div_diff[31:0], acc[30:0], 1'b1};
        else
            acc_step = {mul_sum, acc[31:1]};
    end

    logic [63:0] prod;
    logic [31:0] quo, rem, calc_result;

    always_comb begin
        prod = (sign_a ^ sign_b) ? -acc_step : acc_step;
        quo  = (sign_a ^ sign_b) ? -acc_step[31:0] : acc_step[31:0];
        rem  = sign_a ? -acc_step[63:32] : acc_step[63:32];
        if (op[2]) calc_result = op[1] ? rem : quo;
        else       calc_result = (op[1:0] == 2'b00) ? prod[31:0] : prod[63:32];
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = fast ? DONE : CALC;
            CALC:    if (count == 5'd31) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            op     <= '0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            opnd   <= '0;
            acc    <= '0;
            count  <= '0;
            result <= '0;
            rd_out <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    op     <= funct3;
                    sign_a <= neg_a;
                    sign_b <= neg_b;
                    count  <= '0;
                    rd_out <= rd_in;
                    opnd   <= is_div ? mag_b : mag_a;
                    acc    <= {32'd0, is_div ? mag_a : mag_b};
                    if (fast) result <= fast_result;
                end
                CALC: begin
                    acc   <= acc_step;
                    count <= count + 5'd1;
                    if (count == 5'd31) result <= calc_result;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed spec cases plus randomized ops
// compared against a plain-arithmetic reference model.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] operand_a = '0;
    logic [31:0] operand_b = '0;
    logic [4:0]  rd_in = '0;
    logic        busy, done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int n_cmp = 0;
    int n_err = 0;

    muldiv_unit dut (
        .clk(clk), .rst(rst), .start(start), .funct3(funct3),
        .operand_a(operand_a), .operand_b(operand_b), .rd_in(rd_in),
        .busy(busy), .done(done), .result(result), .rd_out(rd_out)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb, p;
        int sa, sb;
        if (!f[2]) begin
            ea = (f[1:0] != 2'b11) ? {{32{a[31]}}, a} : {32'd0, a};
            eb = (f[1:0] <= 2'b01) ? {{32{b[31]}}, b} : {32'd0, b};
            p  = ea * eb;
            return (f[1:0] == 2'b00) ? p[31:0] : p[63:32];
        end
        if (b == 32'd0) return f[1] ? a : 32'hFFFF_FFFF;
        if (!f[0]) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f[1] ? 32'd0 : 32'h8000_0000;
            sa = a;
            sb = b;
            return f[1] ? 32'(sa % sb) : 32'(sa / sb);
        end
        return f[1] ? a % b : a / b;
    endfunction

    function automatic bit is_fast(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        return f[2] && (b == 32'd0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    // Called just after a falling edge; that cycle is cycle 0 of the request.
    task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp,
                          input int noise_k, input int rst_k);
        int done_k;
        done_k    = is_fast(f, a, b) ? 1 : 33;
        start     = 1'b1;
        funct3    = f;
        operand_a = a;
        operand_b = b;
        rd_in     = rd;
        for (int k = 1; k <= done_k + 1; k++) begin
            @(negedge clk);
            if (rst_k > 0 && k == rst_k + 1) begin
                n_cmp++;
                if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0 || rd_out !== 5'd0) begin
                    n_err++;
                    $display("FAIL %s reset state: busy=%b done=%b result=%h rd_out=%0d, want 0/0/0/0",
                             name, busy, done, result, rd_out);
                end
                rst = 1'b1;
                for (int j = 0; j < 40; j++) begin
                    @(negedge clk);
                    n_cmp++;
                    if (done !== 1'b0 || busy !== 1'b0) begin
                        n_err++;
                        $display("FAIL %s after abort cycle %0d: busy=%b done=%b, want 0/0", name, j, busy, done);
                    end
                end
                return;
            end
            if (!(rst_k > 0 && k > rst_k)) begin
                n_cmp++;
                if (busy !== (k <= done_k)) begin
                    n_err++;
                    $display("FAIL %s busy cycle %0d: got %b want %b", name, k, busy, k <= done_k);
                end
                n_cmp++;
                if (done !== (k == done_k)) begin
                    n_err++;
                    $display("FAIL %s done cycle %0d: got %b want %b", name, k, done, k == done_k);
                end
                if (k >= done_k) begin
                    n_cmp++;
                    if (result !== exp || rd_out !== rd) begin
                        n_err++;
                        $display("FAIL %s result cycle %0d: got %h rd %0d want %h rd %0d",
                                 name, k, result, rd_out, exp, rd);
                    end
                end
            end
            if (k == 1) begin
                start     = 1'b0;
                funct3    = 3'($urandom);
                operand_a = $urandom;
                operand_b = $urandom;
                rd_in     = 5'($urandom);
            end
            if (k == noise_k) begin
                start     = 1'b1;
                funct3    = 3'b000;
                operand_a = 32'd9;
                operand_b = 32'd9;
            end
            if (k == noise_k + 1) start = 1'b0;
            if (k == rst_k) rst = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst   = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0 || rd_out !== 5'd0) begin
            n_err++;
            $display("FAIL reset: busy=%b done=%b result=%h rd_out=%0d, want all zero", busy, done, result, rd_out);
        end
        rst = 1'b1;
    endtask

    task automatic test_mul_timing();
        run_op("mul_7x-3", 3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 0, 0);
    endtask

    task automatic test_high_mul();
        run_op("mulh", 3'b001, 32'h8000_0000, 32'h8000_0000, 5'd1, 32'h4000_0000, 0, 0);
        run_op("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE, 0, 0);
        run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFF, 0, 0);
    endtask

    task automatic test_div();
        run_op("div_-7/2", 3'b100, 32'hFFFF_FFF9, 32'd2, 5'd4, 32'hFFFF_FFFD, 0, 0);
        run_op("rem_-7/2", 3'b110, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF, 0, 0);
        run_op("divu_100/7", 3'b101, 32'd100, 32'd7, 5'd7, 32'd14, 0, 0);
        run_op("remu_100/7", 3'b111, 32'd100, 32'd7, 5'd8, 32'd2, 0, 0);
    endtask

    // Consecutive fast-path requests also exercise the 2-cycle start spacing.
    task automatic test_fast_path();
        run_op("div_by_0", 3'b100, 32'd5, 32'd0, 5'd9, 32'hFFFF_FFFF, 0, 0);
        run_op("remu_by_0", 3'b111, 32'd5, 32'd0, 5'd10, 32'd5, 0, 0);
        run_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 0, 0);
        run_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0, 0, 0);
    endtask

    task automatic test_ignored_start();
        run_op("ignored_start", 3'b000, 32'd3, 32'd4, 5'd13, 32'd12, 5, 0);
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            n_cmp++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL ignored_start idle %0d: busy=%b done=%b, want 0/0", j, busy, done);
            end
        end
    endtask

    task automatic test_reset_abort();
        run_op("abort_divu", 3'b101, 32'd1000, 32'd7, 5'd14, 32'd142, 0, 10);
        run_op("after_abort", 3'b101, 32'd1000, 32'd7, 5'd15, 32'd142, 0, 0);
    endtask

    task automatic test_back_to_back();
        logic [2:0]  f;
        logic [31:0] a, b;
        for (int i = 0; i < 30; i++) begin
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                3: a = 32'($urandom_range(0, 255));
                default: ;
            endcase
            run_op("random", f, a, b, 5'($urandom), ref_result(f, a, b), 0, 0);
        end
    endtask

    initial begin
        test_reset();
        test_mul_timing();
        test_high_mul();
        test_div();
        test_fast_path();
        test_ignored_start();
        test_reset_abort();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
